// File: rtl/fc_argmax_stage.sv
// fc_argmax_stage: forwards the FC logit stream through a 2-entry skid buffer
// while tracking the running argmax over one frame of NUM_CLASSES logits.

// One comparison lane: takes over the running max only when strictly greater.
module fc_argmax_lane #(
  parameter int IDX_WIDTH = 4
) (
  input  logic signed [7:0]      logit,
  input  logic                   en,
  input  logic [IDX_WIDTH-1:0]   cls,
  input  logic signed [7:0]      max_in,
  input  logic [IDX_WIDTH-1:0]   idx_in,
  output logic signed [7:0]      max_out,
  output logic [IDX_WIDTH-1:0]   idx_out
);
  // Strict greater-than: an equal logit in a later lane never displaces the earlier winner
  always_comb begin
    max_out = max_in;
    idx_out = idx_in;
    if (en && (logit > max_in)) begin
      max_out = logit;
      idx_out = cls;
    end
  end
endmodule

module fc_argmax_stage #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_WIDTH   = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  output logic                    S_AXIS_TREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXIS_TKEEP,
  input  logic                    S_AXIS_TUSER,
  input  logic                    S_AXIS_TLAST,
  input  logic                    S_AXIS_TVALID,
  input  logic                    M_AXIS_TREADY,
  output logic                    M_AXIS_TUSER,
  output logic [DATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  output logic                    M_AXIS_TLAST,
  output logic                    M_AXIS_TVALID,
  output logic [IDX_WIDTH-1:0]    max_index,
  output logic [7:0]              max_value,
  output logic                    done,
  output logic                    err_short
);
  localparam int LANES     = DATA_WIDTH / 8;
  localparam int NUM_BEATS = (NUM_CLASSES + LANES - 1) / LANES;
  localparam int BW        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  // one spare bit so class numbers of padding lanes never alias valid ones
  localparam int CW        = BW + $clog2(LANES) + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NUM_BEATS - 1);
  localparam logic [CW-1:0] NC        = CW'(NUM_CLASSES);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [LANES-1:0]      keep;
    logic                  user;
    logic                  last;
  } beat_t;

  state_t            state, state_nxt;
  beat_t             mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        cnt;
  logic [BW-1:0]     beat_cnt;
  logic              accept, pop, last_beat, start_run;

  logic [LANES:0][7:0]           chain_max;
  logic [LANES:0][IDX_WIDTH-1:0] chain_idx;

  assign accept    = S_AXIS_TVALID && S_AXIS_TREADY;
  assign pop       = (cnt != 2'd0) && M_AXIS_TREADY;
  assign last_beat = S_AXIS_TLAST || (beat_cnt == LAST_BEAT);
  assign start_run = start && ((state == IDLE) || (state == DONE));

  // State register
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;

  // Next-state: start is only honoured from IDLE/DONE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN:   if (accept && last_beat) state_nxt = DRAIN;
      DRAIN: if (cnt == 2'd0) state_nxt = DONE;
      DONE:  if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: input only flows in RUN while the buffer has room
  always_comb begin
    S_AXIS_TREADY = (state == RUN) && (cnt != 2'd2);
    done          = (state == DONE);
  end

  // Lane chain evaluated 0 -> LANES-1 so ties resolve to the lowest class
  assign chain_max[0] = max_value;
  assign chain_idx[0] = max_index;

  generate
    for (genvar j = 0; j < LANES; j++) begin : g_lane
      logic [CW-1:0] cls;
      assign cls = CW'(beat_cnt) * CW'(LANES) + CW'(j);
      fc_argmax_lane #(.IDX_WIDTH(IDX_WIDTH)) u_lane (
        .logit   (S_AXIS_TDATA[8*j +: 8]),
        .en      (S_AXIS_TKEEP[j] && (cls < NC)),
        .cls     (cls[IDX_WIDTH-1:0]),
        .max_in  (chain_max[j]),
        .idx_in  (chain_idx[j]),
        .max_out (chain_max[j+1]),
        .idx_out (chain_idx[j+1])
      );
    end
  endgenerate

  // Frame tracking: re-arm on start, fold each accepted beat into the max
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      max_value <= '0;
      max_index <= '0;
      beat_cnt  <= '0;
      err_short <= 1'b0;
    end else if (start_run) begin
      max_value <= 8'h80;
      max_index <= '0;
      beat_cnt  <= '0;
      err_short <= 1'b0;
    end else if (accept) begin
      max_value <= chain_max[LANES];
      max_index <= chain_idx[LANES];
      beat_cnt  <= beat_cnt + 1'b1;
      if (S_AXIS_TLAST && (beat_cnt < LAST_BEAT)) err_short <= 1'b1;
    end

  // Skid buffer: 2-entry FIFO, last is forced on the final counted beat
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= '{data: S_AXIS_TDATA, keep: S_AXIS_TKEEP,
                         user: S_AXIS_TUSER, last: last_beat};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({accept, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end

  assign M_AXIS_TVALID = (cnt != 2'd0);
  assign M_AXIS_TDATA  = mem[rd_ptr].data;
  assign M_AXIS_TKEEP  = mem[rd_ptr].keep;
  assign M_AXIS_TUSER  = mem[rd_ptr].user;
  assign M_AXIS_TLAST  = mem[rd_ptr].last;
endmodule

// File: tb/tb_fc_argmax_stage.sv
// Randomized scoreboard bench for fc_argmax_stage.
module tb_fc_argmax_stage;
  localparam int NC = 10;
  localparam int NB = 3;

  logic        clk = 1'b0;
  logic        rstn, start;
  logic        S_AXIS_TREADY;
  logic [31:0] S_AXIS_TDATA;
  logic [3:0]  S_AXIS_TKEEP;
  logic        S_AXIS_TUSER, S_AXIS_TLAST, S_AXIS_TVALID;
  logic        M_AXIS_TREADY = 1'b0;
  logic        M_AXIS_TUSER;
  logic [31:0] M_AXIS_TDATA;
  logic [3:0]  M_AXIS_TKEEP;
  logic        M_AXIS_TLAST, M_AXIS_TVALID;
  logic [3:0]  max_index;
  logic [7:0]  max_value;
  logic        done, err_short;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        user;
    logic        last;
  } beat_t;

  beat_t expq[$];
  int    lg_q[$];
  int    li_q[$];
  int    k_in_frame;
  bit    exp_err;
  bit    rnd_ready = 1'b0;
  bit    ready_fixed = 1'b1;
  int    checks = 0;
  int    errors = 0;

  fc_argmax_stage dut (
    .clk(clk), .rstn(rstn), .start(start),
    .S_AXIS_TREADY(S_AXIS_TREADY), .S_AXIS_TDATA(S_AXIS_TDATA),
    .S_AXIS_TKEEP(S_AXIS_TKEEP), .S_AXIS_TUSER(S_AXIS_TUSER),
    .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TVALID(S_AXIS_TVALID),
    .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TUSER(M_AXIS_TUSER),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TKEEP(M_AXIS_TKEEP),
    .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TVALID(M_AXIS_TVALID),
    .max_index(max_index), .max_value(max_value),
    .done(done), .err_short(err_short)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // downstream ready: fixed level or random backpressure
  always @(posedge clk) begin
    #1;
    M_AXIS_TREADY = rnd_ready ? ($urandom_range(3) != 0) : ready_fixed;
  end

  // monitor: every output handshake must match the oldest expected beat
  always @(negedge clk) begin
    beat_t e;
    if (rstn && M_AXIS_TVALID && M_AXIS_TREADY) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got beat %h with nothing expected", M_AXIS_TDATA);
      end else begin
        e = expq.pop_front();
        chk("out_beat", {M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TUSER, M_AXIS_TLAST}, e);
      end
    end
  end

  // reference: argmax over participating logits in class order, strict >
  task automatic model_max(output int idx, output int val);
    val = -128;
    idx = 0;
    foreach (lg_q[i]) if (lg_q[i] > val) begin val = lg_q[i]; idx = li_q[i]; end
  endtask

  task automatic begin_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k_in_frame = 0;
    exp_err = 1'b0;
    lg_q.delete();
    li_q.delete();
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic [3:0] kp, input logic l,
                            input bit gaps);
    int n;
    byte b;
    logic u;
    if (gaps) repeat ($urandom_range(2)) begin @(posedge clk); #1; end
    u = 1'($urandom);
    S_AXIS_TDATA = d; S_AXIS_TKEEP = kp; S_AXIS_TUSER = u; S_AXIS_TLAST = l;
    S_AXIS_TVALID = 1'b1;
    n = 0;
    @(negedge clk);
    while (!S_AXIS_TREADY && n < 300) begin @(negedge clk); n++; end
    if (!S_AXIS_TREADY) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: beat %0d never accepted", k_in_frame);
      S_AXIS_TVALID = 1'b0;
      return;
    end
    @(posedge clk); #1;
    S_AXIS_TVALID = 1'b0;
    expq.push_back({d, kp, u, l || (k_in_frame == NB-1)});
    for (int j = 0; j < 4; j++) begin
      b = d[8*j +: 8];
      if (kp[j] && (4*k_in_frame + j < NC)) begin
        lg_q.push_back(int'(b));
        li_q.push_back(4*k_in_frame + j);
      end
    end
    if (l && k_in_frame < NB-1) exp_err = 1'b1;
    k_in_frame++;
  endtask

  task automatic send_beats(input logic [31:0] dat [4], input logic [3:0] kp [4],
                            input int tl_at, input bit gaps);
    for (int k = 0; k < 4; k++) begin
      drive_beat(dat[k], kp[k], k == tl_at, gaps);
      if (k == tl_at || k == NB-1) break;
    end
  endtask

  task automatic finish_frame(input string nm, output int lat);
    int ei, ev;
    lat = 0;
    while (!done && lat < 500) begin @(posedge clk); #1; lat++; end
    chk({nm, "_done"}, done, 1'b1);
    model_max(ei, ev);
    chk({nm, "_idx"}, max_index, ei[3:0]);
    chk({nm, "_val"}, max_value, ev[7:0]);
    chk({nm, "_err"}, err_short, exp_err);
    chk({nm, "_drained"}, {M_AXIS_TVALID, 31'(expq.size())}, 32'd0);
  endtask

  initial begin
    logic [31:0] dat [4];
    logic [3:0]  kp [4];
    int lat, tl, ok;
    rstn = 1'b0; start = 1'b0;
    S_AXIS_TDATA = '0; S_AXIS_TKEEP = '0; S_AXIS_TUSER = 1'b0;
    S_AXIS_TLAST = 1'b0; S_AXIS_TVALID = 1'b0;
    kp = '{4'hF, 4'hF, 4'hF, 4'hF};
    #22;
    chk("rst_outputs", {S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TKEEP,
                        M_AXIS_TLAST, M_AXIS_TUSER, done, err_short}, 64'd0);
    chk("rst_max", {max_index, max_value}, 12'd0);
    @(posedge clk); #1; rstn = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("idle_tready", S_AXIS_TREADY, 1'b0);

    // basic max, latency of done after drain
    begin_frame();
    chk("start_init", {max_index, max_value}, {4'd0, 8'h80});
    dat = '{32'h04030201, 32'h08070605, 32'h00000A09, 32'h0};
    send_beats(dat, kp, 2, 0);
    finish_frame("basic", lat);
    chk("basic_const", {max_index, max_value}, {4'd9, 8'h0A});
    chk("basic_done_lat", lat, 2);

    // negatives and ties
    begin_frame();
    dat = '{32'h7FF0F0F0, 32'h7FF0F0F0, 32'hF0F0F0F0, 32'h0};
    send_beats(dat, kp, 2, 0);
    finish_frame("ties", lat);
    chk("ties_const", {max_index, max_value}, {4'd3, 8'h7F});

    // lanes beyond NUM_CLASSES ignored
    begin_frame();
    dat = '{32'h0, 32'h0, 32'h7F7F0000, 32'h0};
    send_beats(dat, kp, 2, 0);
    finish_frame("pad", lat);
    chk("pad_const", {max_index, max_value}, {4'd0, 8'h00});

    // backpressure
    ready_fixed = 1'b0;
    @(posedge clk); #1;
    begin_frame();
    drive_beat(32'h11223344, 4'hF, 1'b0, 0);
    drive_beat(32'h55667788, 4'hF, 1'b0, 0);
    @(negedge clk);
    chk("bp_tready_low", {S_AXIS_TREADY, M_AXIS_TVALID}, 2'b01);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_done", done, 1'b0);
    ready_fixed = 1'b1;
    drive_beat(32'h99AABBCC, 4'hF, 1'b1, 0);
    finish_frame("bp", lat);

    // short frame
    begin_frame();
    dat = '{$urandom, $urandom, $urandom, $urandom};
    send_beats(dat, kp, 1, 0);
    finish_frame("short", lat);
    chk("short_err", err_short, 1'b1);

    // long frame: 4th beat must be refused
    begin_frame();
    dat = '{$urandom, $urandom, $urandom, $urandom};
    send_beats(dat, kp, -1, 0);
    S_AXIS_TDATA = 32'hDEADBEEF; S_AXIS_TLAST = 1'b0; S_AXIS_TVALID = 1'b1;
    ok = 1;
    repeat (4) begin @(negedge clk); if (S_AXIS_TREADY) ok = 0; end
    S_AXIS_TVALID = 1'b0;
    chk("long_4th_refused", ok, 1);
    finish_frame("long", lat);

    // reset mid-frame
    ready_fixed = 1'b0;
    @(posedge clk); #1;
    begin_frame();
    drive_beat(32'h01020304, 4'hF, 1'b0, 0);
    drive_beat(32'h05060708, 4'hF, 1'b0, 0);
    chk("rst_pre_valid", M_AXIS_TVALID, 1'b1);
    rstn = 1'b0;
    #1;
    chk("midrst_outputs", {S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST,
                           done, err_short, max_index, max_value}, 64'd0);
    expq.delete();
    @(posedge clk); #1; rstn = 1'b1; ready_fixed = 1'b1;
    @(posedge clk); #1;
    begin_frame();
    dat = '{$urandom, $urandom, $urandom, $urandom};
    send_beats(dat, kp, 2, 0);
    finish_frame("restart", lat);
    begin_frame();
    send_beats(dat, kp, 0, 0);
    finish_frame("restart_short", lat);
    begin_frame();
    chk("restart_clear", {done, err_short}, 2'b00);
    send_beats(dat, kp, 2, 0);
    finish_frame("restart_full", lat);

    // random frames with random backpressure and gaps
    rnd_ready = 1'b1;
    for (int f = 0; f < 25; f++) begin
      for (int k = 0; k < 4; k++) begin
        dat[k] = $urandom;
        kp[k]  = ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF;
      end
      case ($urandom_range(4))
        0: tl = 0;
        1: tl = 1;
        4: tl = -1;
        default: tl = 2;
      endcase
      begin_frame();
      send_beats(dat, kp, tl, 1);
      finish_frame("rand", lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
